// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: scans enabled rows of a 3-to-8 decoder with blanking and programmable dwell.
// Define SCAN_FRAME_CNT_EN to add the 16-bit frame_count output.
module decoder_scan_sequencer #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         row_mask,
    output logic               sel_a,
    output logic               sel_b,
    output logic               sel_c,
    output logic               dec_en,
    output logic               busy,
`ifdef SCAN_FRAME_CNT_EN
    output logic [15:0]        frame_count,
`endif
    output logic               frame_done
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BLANK  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
    localparam int CW = DWELL_W > BW ? DWELL_W : BW;

    logic [1:0]         state, state_n;
    logic [2:0]         row, row_n, lo, nxt;
    logic [CW-1:0]      cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dq_n;
    logic               stop_pend, sp_n, has_nxt, wrap, halt, go;

    always_comb begin
        lo      = 3'd0;
        nxt     = 3'd0;
        has_nxt = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (row_mask[i]) lo = 3'(i);
            if (row_mask[i] && 3'(i) > row) begin
                nxt     = 3'(i);
                has_nxt = 1'b1;
            end
        end
        halt    = stop_pend || row_mask == 8'd0;
        go      = state == IDLE && start && !stop && row_mask != 8'd0;
        wrap    = state == ACTIVE && cnt == CW'(dwell_q) && !has_nxt;
        state_n = state;
        row_n   = row;
        dq_n    = dwell_q;
        cnt_n   = cnt + CW'(1);
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (go) {state_n, row_n, dq_n} = {BLANK, lo, dwell};
            end
            BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) {state_n, cnt_n} = {ACTIVE, CW'(0)};
            ACTIVE: if (cnt == CW'(dwell_q)) begin
                cnt_n = '0;
                if (has_nxt) {state_n, row_n} = {BLANK, nxt};
                else if (halt) state_n = IDLE;
                else {state_n, row_n, dq_n} = {BLANK, lo, dwell};
            end
            default: {state_n, cnt_n} = {IDLE, CW'(0)};
        endcase
        // a stop seen on the final cycle still counts once the frame has wrapped into a new one
        sp_n = (wrap && halt) ? 1'b0 : stop_pend | (stop && state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= 3'd0;
            cnt        <= '0;
            dwell_q    <= '0;
            stop_pend  <= 1'b0;
            dec_en     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            cnt        <= cnt_n;
            dwell_q    <= dq_n;
            stop_pend  <= sp_n;
            dec_en     <= state_n == ACTIVE;
            busy       <= state_n != IDLE;
            frame_done <= wrap;
        end
    end

`ifdef SCAN_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_count <= 16'd0;
        else if (wrap) frame_count <= frame_count + 16'd1;
    end
`endif

    assign {sel_a, sel_b, sel_c} = row;
endmodule
